// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN datapath stages (window generator, MAC, activation, pooling).
// Window elements are packed row-major, oldest row and oldest column at the lowest index.
package cnn_pkg;

    localparam int CNN_DATA_WIDTH = 8;
    localparam int CNN_SIZE       = 3;

    function automatic int win_idx(input int r, input int k);
        return r * CNN_SIZE + k;
    endfunction

    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/cnn_line_buffer.sv
// One image row of pixel storage: combinational read, write on enable, read-before-write.
// Contents are deliberately not reset; stale data is masked by the window generator.
module cnn_line_buffer
    import cnn_pkg::*;
#(
    parameter int DEPTH      = 8,
    parameter int DATA_WIDTH = CNN_DATA_WIDTH,
    parameter int ADDR_W     = clog2_min1(DEPTH)
) (
    input  logic                  clk,
    input  logic [ADDR_W-1:0]     addr,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    assign rd_data = mem[addr];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wr_data;
        end
    end

endmodule

// File: rtl/conv_window_gen.sv
// Streaming 3x3 sliding-window generator feeding the convolution MAC matrix input.
// Raster-order pixels in, one flattened window out per fully-interior position.
module conv_window_gen
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = CNN_DATA_WIDTH,
    parameter int SIZE       = CNN_SIZE,
    parameter int IMG_W      = 8,
    parameter int IMG_H      = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            s_valid,
    output logic                            s_ready,
    input  logic [DATA_WIDTH-1:0]           s_data,
    output logic                            m_valid,
    input  logic                            m_ready,
    output logic [SIZE*SIZE*DATA_WIDTH-1:0] m_window,
    output logic                            m_last
);

    localparam int COL_W = clog2_min1(IMG_W);
    localparam int ROW_W = clog2_min1(IMG_H);
    localparam int WIN_W = SIZE * SIZE * DATA_WIDTH;

    generate
        if (SIZE != 3) begin : g_bad_size
            $error("conv_window_gen supports SIZE == 3 only");
        end
        if (IMG_W < SIZE || IMG_H < SIZE) begin : g_bad_img
            $error("conv_window_gen needs IMG_W and IMG_H >= SIZE");
        end
    endgenerate

    logic [COL_W-1:0]      col_q;
    logic [ROW_W-1:0]      row_q;
    logic                  accept;
    logic                  produce;
    logic                  last_pos;
    logic [DATA_WIDTH-1:0] lb1_rd;
    logic [DATA_WIDTH-1:0] lb2_rd;
    logic [DATA_WIDTH-1:0] win_q   [SIZE][SIZE];
    logic [DATA_WIDTH-1:0] win_nxt [SIZE][SIZE];
    logic [WIN_W-1:0]      win_flat;

    // A pending window blocks all input so nothing is lost under backpressure.
    assign s_ready  = !m_valid || m_ready;
    assign accept   = s_valid && s_ready;
    assign produce  = accept && (row_q >= ROW_W'(2)) && (col_q >= COL_W'(2));
    assign last_pos = (row_q == ROW_W'(IMG_H - 1)) && (col_q == COL_W'(IMG_W - 1));

    cnn_line_buffer #(
        .DEPTH      (IMG_W),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (COL_W)
    ) u_lb1 (
        .clk     (clk),
        .addr    (col_q),
        .we      (accept),
        .wr_data (s_data),
        .rd_data (lb1_rd)
    );

    cnn_line_buffer #(
        .DEPTH      (IMG_W),
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_W     (COL_W)
    ) u_lb2 (
        .clk     (clk),
        .addr    (col_q),
        .we      (accept),
        .wr_data (lb1_rd),
        .rd_data (lb2_rd)
    );

    always_comb begin
        for (int r = 0; r < SIZE; r++) begin
            for (int k = 0; k < SIZE - 1; k++) begin
                win_nxt[r][k] = win_q[r][k+1];
            end
        end
        win_nxt[0][SIZE-1] = lb2_rd;
        win_nxt[1][SIZE-1] = lb1_rd;
        win_nxt[2][SIZE-1] = s_data;
    end

    always_comb begin
        win_flat = '0;
        for (int r = 0; r < SIZE; r++) begin
            for (int k = 0; k < SIZE; k++) begin
                win_flat[win_idx(r, k)*DATA_WIDTH +: DATA_WIDTH] = win_nxt[r][k];
            end
        end
    end

    // Pure data path; only fully refilled columns ever reach the output.
    always_ff @(posedge clk) begin
        if (accept) begin
            win_q <= win_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col_q <= '0;
            row_q <= '0;
        end else if (accept) begin
            if (col_q == COL_W'(IMG_W - 1)) begin
                col_q <= '0;
                if (row_q == ROW_W'(IMG_H - 1)) begin
                    row_q <= '0;
                end else begin
                    row_q <= row_q + ROW_W'(1);
                end
            end else begin
                col_q <= col_q + COL_W'(1);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_valid  <= 1'b0;
            m_last   <= 1'b0;
            m_window <= '0;
        end else if (produce) begin
            m_valid  <= 1'b1;
            m_window <= win_flat;
            m_last   <= last_pos;
        end else if (m_ready) begin
            m_valid  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_window_gen.sv
// Directed bench for conv_window_gen on a 4x4 image: cycle-level reference model plus
// hand-computed window lists for single, backpressured, bubbled, back-to-back and reset cases.
module tb_conv_window_gen;

    localparam int DW = 8;
    localparam int W  = 4;
    localparam int H  = 4;
    localparam int WB = 9 * DW;

    // Hand-computed windows of a 4x4 frame holding 1..16, element index 0..8.
    localparam int OFS [4][9] = '{
        '{1, 2, 3, 5, 6, 7,  9, 10, 11},
        '{2, 3, 4, 6, 7, 8, 10, 11, 12},
        '{5, 6, 7, 9, 10, 11, 13, 14, 15},
        '{6, 7, 8, 10, 11, 12, 14, 15, 16}
    };

    logic          clk = 1'b0;
    logic          rst;
    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [WB-1:0] m_window;
    logic          m_last;

    int checks = 0;
    int errors = 0;

    bit            mon_en = 1'b0;
    bit            pend   = 1'b0;
    bit            exp_last;
    logic [WB-1:0] exp_win;
    int            pr = 0;
    int            pc = 0;
    logic [DW-1:0] img [H][W];
    logic [WB-1:0] q_win [$];
    bit            q_last [$];
    int            sready_low = 0;
    int            mvalid_cyc = 0;
    int            q_base = 0;

    always #5 clk = ~clk;

    conv_window_gen #(
        .DATA_WIDTH (DW),
        .SIZE       (3),
        .IMG_W      (W),
        .IMG_H      (H)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .s_valid  (s_valid),
        .s_ready  (s_ready),
        .s_data   (s_data),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_window (m_window),
        .m_last   (m_last)
    );

    task automatic check(input string tag, input logic [WB-1:0] obs, input logic [WB-1:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [WB-1:0] pk(input int j, input int base);
        logic [WB-1:0] v;
        v = '0;
        for (int i = 0; i < 9; i++) begin
            v[i*DW +: DW] = DW'(OFS[j][i] + base);
        end
        return v;
    endfunction

    // Reference model, evaluated on the falling edge for the next rising edge.
    always @(negedge clk) begin
        bit exp_sready;
        if (rst) begin
            pend = 1'b0;
            pr   = 0;
            pc   = 0;
        end else if (mon_en) begin
            exp_sready = !pend || m_ready;
            check("s_ready", s_ready, exp_sready);
            check("m_valid", m_valid, pend);
            if (pend) begin
                check("m_window", m_window, exp_win);
                check("m_last", m_last, exp_last);
            end
            if (!s_ready) sready_low++;
            if (m_valid) mvalid_cyc++;
            if (m_valid && m_ready) begin
                q_win.push_back(m_window);
                q_last.push_back(m_last);
            end
            if (pend && m_ready) pend = 1'b0;
            if (s_valid && exp_sready) begin
                img[pr][pc] = s_data;
                if (pr >= 2 && pc >= 2) begin
                    pend = 1'b1;
                    for (int rr = 0; rr < 3; rr++) begin
                        for (int k = 0; k < 3; k++) begin
                            exp_win[(rr*3+k)*DW +: DW] = img[pr-2+rr][pc-2+k];
                        end
                    end
                    exp_last = (pr == H - 1) && (pc == W - 1);
                end
                pc++;
                if (pc == W) begin
                    pc = 0;
                    pr = (pr == H - 1) ? 0 : pr + 1;
                end
            end
        end
    end

    task automatic run(input int n, input int first, input bit bubble, input bit bp);
        int sent  = 0;
        int cyc   = 0;
        int stall = 0;
        bit seen  = 1'b0;
        bit acc;
        while (sent < n && cyc < 400) begin
            s_valid = bubble ? (cyc % 2 == 0) : 1'b1;
            s_data  = DW'(first + sent);
            if (bp && m_valid && !seen) begin
                seen  = 1'b1;
                stall = 3;
            end
            m_ready = (stall > 0) ? 1'b0 : 1'b1;
            if (stall > 0) stall--;
            @(negedge clk);
            acc = s_valid && s_ready;
            @(posedge clk);
            #1;
            if (acc) sent++;
            cyc++;
        end
        check("run_timeout", sent, n);
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic cmp_frames(input string tag, input int nf);
        int n;
        n = q_win.size() - q_base;
        check({tag, "_count"}, n, 4 * nf);
        for (int j = 0; j < n && j < 4 * nf; j++) begin
            check({tag, "_win"}, q_win[q_base+j], pk(j % 4, 16 * (j / 4)));
            check({tag, "_last"}, q_last[q_base+j], (j % 4 == 3));
        end
        q_base = q_win.size();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_m_valid", m_valid, 1'b0);
        check("rst_m_last", m_last, 1'b0);
        check("rst_m_window", m_window, '0);
        rst = 1'b0;
        #1;
        check("rst_s_ready", s_ready, 1'b1);
    endtask

    initial begin
        int lo0;
        int mv0;
        rst     = 1'b1;
        s_valid = 1'b0;
        s_data  = '0;
        m_ready = 1'b1;
        do_reset();
        mon_en = 1'b1;

        run(16, 1, 1'b0, 1'b0);
        cmp_frames("single", 1);

        lo0 = sready_low;
        run(16, 1, 1'b0, 1'b1);
        check("bp_sready_low", sready_low - lo0, 3);
        cmp_frames("bp", 1);

        run(16, 1, 1'b1, 1'b0);
        cmp_frames("bubble", 1);

        lo0 = sready_low;
        mv0 = mvalid_cyc;
        run(32, 1, 1'b0, 1'b0);
        check("b2b_sready_low", sready_low - lo0, 0);
        check("b2b_mvalid_cycles", mvalid_cyc - mv0, 8);
        cmp_frames("b2b", 2);

        run(6, 1, 1'b0, 1'b0);
        do_reset();
        run(16, 1, 1'b0, 1'b0);
        cmp_frames("rst_mid", 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
